// File: rtl/i2c_accel_sequencer_pkg.sv
// Shared state encoding, bus constants and the power-on configuration table
// for the accelerometer I2C sequencer.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_CFG_ISSUE,
    S_CFG_WAIT,
    S_PTR_ISSUE,
    S_PTR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PERIOD,
    S_GAP,
    S_FAULT
  } seq_state_t;

  localparam logic [7:0] CHIP_W   = 8'h3A;
  localparam logic [7:0] CHIP_R   = 8'h3B;
  localparam logic [7:0] DATA_REG = 8'h32;
  localparam int         CFG_LEN  = 3;
  localparam int         IDX_W    = 2;

  // Returns {register, value} for configuration entry idx.
  function automatic logic [15:0] cfg_entry(input logic [IDX_W-1:0] idx);
    logic [15:0] entry;
    case (idx)
      2'd0:    entry = {8'h2D, 8'h08};
      2'd1:    entry = {8'h31, 8'h0B};
      default: entry = {8'h2C, 8'h0A};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/i2c_accel_sequencer_if.sv
// Request/response signals between the sequencer (master) and I2C_Bus (slave).
interface i2c_accel_sequencer_if;
  logic        i2c_en;
  logic        i2c_wr;
  logic [31:0] i2c_wdata;
  logic [31:0] i2c_rdata;
  logic [4:0]  i2c_nm;
  logic        i2c_done;
  logic        i2c_error;
  logic [23:0] i2c_readdata;

  modport master (
    output i2c_en, i2c_wr, i2c_wdata, i2c_rdata, i2c_nm,
    input  i2c_done, i2c_error, i2c_readdata
  );

  modport slave (
    input  i2c_en, i2c_wr, i2c_wdata, i2c_rdata, i2c_nm,
    output i2c_done, i2c_error, i2c_readdata
  );
endinterface

// File: rtl/i2c_accel_sequencer_timer.sv
// Loadable down-counter: after a load of N, zero is reached N-1 cycles later,
// so a state that leaves on zero lasts exactly N cycles.
module i2c_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)            cnt_q <= '0;
    else if (load)           cnt_q <= load_val - W'(1);
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_accel_sequencer.sv
// Accelerometer I2C sequencer: configuration writes, then periodic 3-byte polls.
// Define I2C_SEQ_TIMEOUT_EN to add a 16-bit watchdog on every *_WAIT state.
module i2c_accel_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int PWRUP_CYC = 4000,
  parameter int GAP_CYC   = 8,
  parameter int MAX_RETRY = 3,
  parameter int PERIOD_W  = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [PERIOD_W-1:0]   period,
  i2c_accel_sequencer_if.master bus,
  output logic [23:0]           sample_data,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  fault
);

  localparam int CNT_W   = (PERIOD_W > 16) ? PERIOD_W : 16;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  seq_state_t           state_q, state_d, gap_next_q, gap_next_d;
  logic [IDX_W-1:0]     idx_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 run_q;
  logic                 tmr_load, tmr_zero;
  logic [CNT_W-1:0]     tmr_val;
  logic                 in_wait, txn_end, txn_err, txn_ok, retry_max, wdog_hit;

  i2c_seq_timer #(.W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign in_wait   = state_q inside {S_CFG_WAIT, S_PTR_WAIT, S_RD_WAIT};
  assign txn_end   = in_wait && (bus.i2c_done || wdog_hit);
  assign txn_err   = in_wait && ((bus.i2c_done && bus.i2c_error) || wdog_hit);
  assign txn_ok    = txn_end && !txn_err;
  assign retry_max = (retry_q == RETRY_W'(MAX_RETRY));

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] wdog_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)     wdog_q <= '0;
    else if (in_wait) wdog_q <= wdog_q + 16'd1;
    else              wdog_q <= '0;
  end

  assign wdog_hit = in_wait && (wdog_q == 16'hFFFF);
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gap_next_q <= S_IDLE;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_PWRUP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PWRUP_CYC);
        end
      end
      S_PWRUP: begin
        if (!run)          state_d = S_IDLE;
        else if (tmr_zero) state_d = S_CFG_ISSUE;
      end
      S_CFG_ISSUE: state_d = S_CFG_WAIT;
      S_PTR_ISSUE: state_d = S_PTR_WAIT;
      S_RD_ISSUE:  state_d = S_RD_WAIT;
      S_CFG_WAIT, S_PTR_WAIT, S_RD_WAIT: begin
        if (txn_end) begin
          if (txn_err && retry_max) begin
            state_d = S_FAULT;
          end else if (!run) begin
            state_d = S_IDLE;
          end else if (txn_ok && state_q == S_RD_WAIT) begin
            state_d  = S_PERIOD;
            tmr_load = 1'b1;
            tmr_val  = (period == '0) ? CNT_W'(1) : CNT_W'(period);
          end else begin
            state_d  = S_GAP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(GAP_CYC);
            // A failed transaction reissues itself; a good one advances the list.
            if (state_q == S_CFG_WAIT) begin
              if (txn_ok && idx_q == IDX_W'(CFG_LEN - 1)) gap_next_d = S_PTR_ISSUE;
              else                                        gap_next_d = S_CFG_ISSUE;
            end else if (state_q == S_PTR_WAIT && txn_err) begin
              gap_next_d = S_PTR_ISSUE;
            end else begin
              gap_next_d = S_RD_ISSUE;
            end
          end
        end
      end
      S_PERIOD: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          state_d    = S_GAP;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(GAP_CYC);
          gap_next_d = S_PTR_ISSUE;
        end
      end
      S_GAP: begin
        if (!run)          state_d = S_IDLE;
        else if (tmr_zero) state_d = gap_next_q;
      end
      S_FAULT: begin
        if (run && !run_q) begin
          state_d  = S_PWRUP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PWRUP_CYC);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      idx_q         <= '0;
      retry_q       <= '0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      bus.i2c_wr    <= 1'b0;
      bus.i2c_wdata <= '0;
      bus.i2c_rdata <= '0;
      bus.i2c_nm    <= '0;
    end else begin
      run_q        <= run;
      sample_valid <= 1'b0;
      if (state_d == S_PWRUP && state_q != S_PWRUP) begin
        idx_q   <= '0;
        retry_q <= '0;
      end else if (txn_ok) begin
        retry_q <= '0;
        if (state_q == S_CFG_WAIT) idx_q <= idx_q + IDX_W'(1);
      end else if (txn_err && !retry_max) begin
        retry_q <= retry_q + RETRY_W'(1);
      end
      if (txn_ok && state_q == S_RD_WAIT) begin
        sample_data  <= bus.i2c_readdata;
        sample_valid <= 1'b1;
      end
      // Frames are loaded on entry to *_ISSUE and then held through *_WAIT.
      if (state_d == S_CFG_ISSUE) begin
        bus.i2c_wdata <= {8'h00, CHIP_W, cfg_entry(idx_q)};
        bus.i2c_nm    <= 5'd3;
        bus.i2c_wr    <= 1'b0;
      end else if (state_d == S_PTR_ISSUE) begin
        bus.i2c_wdata <= {16'h0000, CHIP_W, DATA_REG};
        bus.i2c_nm    <= 5'd2;
        bus.i2c_wr    <= 1'b0;
      end else if (state_d == S_RD_ISSUE) begin
        bus.i2c_rdata <= {CHIP_R, 24'h000000};
        bus.i2c_nm    <= 5'd4;
        bus.i2c_wr    <= 1'b1;
      end
    end
  end

  assign busy       = state_q inside {S_CFG_ISSUE, S_CFG_WAIT, S_PTR_ISSUE,
                                      S_PTR_WAIT, S_RD_ISSUE, S_RD_WAIT};
  assign bus.i2c_en = busy;
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_i2c_accel_sequencer.sv
// Scoreboard bench for i2c_accel_sequencer: an acking/NACKing bus model checks
// each issued frame against a queue of expected frames and each sample strobe.
module tb_i2c_accel_sequencer;

  localparam int PWRUP_CYC = 4000;
  localparam int GAP_CYC   = 8;
  localparam int MAX_RETRY = 3;
  localparam int PERIOD_W  = 16;
  localparam int LAT       = 4;

  typedef struct packed {
    logic        wr;
    logic [4:0]  nm;
    logic [31:0] data;
  } frame_t;

  localparam frame_t CFG0 = '{wr: 1'b0, nm: 5'd3, data: 32'h003A2D08};
  localparam frame_t CFG1 = '{wr: 1'b0, nm: 5'd3, data: 32'h003A310B};
  localparam frame_t CFG2 = '{wr: 1'b0, nm: 5'd3, data: 32'h003A2C0A};
  localparam frame_t PTR  = '{wr: 1'b0, nm: 5'd2, data: 32'h00003A32};
  localparam frame_t RD   = '{wr: 1'b1, nm: 5'd4, data: 32'h3B000000};

  logic                clk_in = 1'b0;
  logic                reset_n = 1'b0;
  logic                run = 1'b0;
  logic [PERIOD_W-1:0] period = 16'd20;
  logic [23:0]         sample_data;
  logic                sample_valid, busy, fault;

  i2c_accel_sequencer_if bus ();

  i2c_accel_sequencer #(
    .PWRUP_CYC (PWRUP_CYC),
    .GAP_CYC   (GAP_CYC),
    .MAX_RETRY (MAX_RETRY),
    .PERIOD_W  (PERIOD_W)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .run          (run),
    .period       (period),
    .bus          (bus),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .fault        (fault)
  );

  initial forever #5 clk_in = ~clk_in;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          run_cyc = 0;
  int          valid_cyc = 0;
  int          samples_seen = 0;
  int          en_cnt = 0;
  int          nack_cfg1 = 0;
  int          nack_rd = 0;
  bit          period_check_en = 1'b0;
  bit          period_armed = 1'b0;
  frame_t      exp_frames[$];
  logic [23:0] exp_samples[$];
  logic [23:0] rd_values[$];
  frame_t      mon_f;
  logic [23:0] rd_v;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queues the frames a restart should produce, arms the NACK plan, raises run.
  task automatic applyStimulus(input int cfg1_nacks, input int extra_polls);
    exp_frames.push_back(CFG0);
    for (int i = 0; i <= cfg1_nacks; i++) exp_frames.push_back(CFG1);
    exp_frames.push_back(CFG2);
    for (int i = 0; i <= extra_polls; i++) begin
      exp_frames.push_back(PTR);
      exp_frames.push_back(RD);
    end
    nack_cfg1 = cfg1_nacks;
    run_cyc   = cyc;
    run       = 1'b1;
  endtask

  task automatic waitSamples(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && samples_seen < n; i++) @(negedge clk_in);
    checkOutput(tag, 32'(samples_seen >= n), 32'd1);
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Bus model: acks after LAT cycles of en, NACKs as planned, checks frames.
  initial begin
    bus.i2c_done     = 1'b0;
    bus.i2c_error    = 1'b0;
    bus.i2c_readdata = '0;
    forever begin
      @(negedge clk_in);
      bus.i2c_done = 1'b0;
      if (!bus.i2c_en) begin
        bus.i2c_error = 1'b0;
        en_cnt = 0;
      end else begin
        en_cnt++;
        if (en_cnt == 1) begin
          checkOutput("frame_q_depth", 32'(exp_frames.size() > 0), 32'd1);
          if (exp_frames.size() > 0) begin
            mon_f = exp_frames.pop_front();
            checkOutput("frame_wr", 32'(bus.i2c_wr), 32'(mon_f.wr));
            checkOutput("frame_nm", 32'(bus.i2c_nm), 32'(mon_f.nm));
            checkOutput("frame_data", mon_f.wr ? bus.i2c_rdata : bus.i2c_wdata, mon_f.data);
          end
          if (period_armed && !bus.i2c_wr) begin
            checkOutput("period_gap", 32'(cyc - valid_cyc), 32'(int'(period) + GAP_CYC));
            period_armed = 1'b0;
          end
        end
        if (en_cnt == LAT) begin
          if (bus.i2c_wr && nack_rd > 0) begin
            bus.i2c_error = 1'b1;
            nack_rd--;
          end else if (!bus.i2c_wr && bus.i2c_wdata == CFG1.data && nack_cfg1 > 0) begin
            bus.i2c_error = 1'b1;
            nack_cfg1--;
          end else if (bus.i2c_wr) begin
            rd_v = (rd_values.size() > 0) ? rd_values.pop_front() : 24'($urandom);
            bus.i2c_readdata = rd_v;
            exp_samples.push_back(rd_v);
          end
          bus.i2c_done = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (sample_valid) begin
      samples_seen++;
      checkOutput("sample_q_depth", 32'(exp_samples.size() > 0), 32'd1);
      if (exp_samples.size() > 0) checkOutput("sample_data", 32'(sample_data), 32'(exp_samples.pop_front()));
      valid_cyc = cyc;
      if (period_check_en) period_armed = 1'b1;
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    checkOutput("rst_en", 32'(bus.i2c_en), 32'd0);
    checkOutput("rst_wr", 32'(bus.i2c_wr), 32'd0);
    checkOutput("rst_wdata", bus.i2c_wdata, 32'd0);
    checkOutput("rst_rdata", bus.i2c_rdata, 32'd0);
    checkOutput("rst_nm", 32'(bus.i2c_nm), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_in);

    // Clean bring-up with two polls; one IDLE cycle then PWRUP_CYC cycles.
    rd_values.push_back(24'h123456);
    rd_values.push_back(24'h654321);
    period_check_en = 1'b1;
    applyStimulus(0, 1);
    for (int i = 0; i < PWRUP_CYC + 100 && !bus.i2c_en; i++) @(negedge clk_in);
    checkOutput("pwrup_timeout", 32'(bus.i2c_en), 32'd1);
    checkOutput("pwrup_len", 32'(cyc - run_cyc), 32'(PWRUP_CYC + 1));
    waitSamples(2, 1000, "poll_timeout");
    period_check_en = 1'b0;
    period_armed    = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_en", 32'(bus.i2c_en), 32'd0);

    // Config entry 1 NACKed twice, then the chain continues without fault.
    rd_values.push_back(24'h0F1E2D);
    applyStimulus(2, 0);
    waitSamples(3, PWRUP_CYC + 1000, "retry_timeout");
    checkOutput("retry_fault", 32'(fault), 32'd0);

    // Next poll: the read NACKs four times in a row and the sequencer faults.
    exp_frames.push_back(PTR);
    for (int i = 0; i <= MAX_RETRY; i++) exp_frames.push_back(RD);
    nack_rd = MAX_RETRY + 1;
    for (int i = 0; i < 500 && !fault; i++) @(negedge clk_in);
    checkOutput("fault_set", 32'(fault), 32'd1);
    checkOutput("fault_en", 32'(bus.i2c_en), 32'd0);
    checkOutput("fault_busy", 32'(busy), 32'd0);
    checkOutput("fault_frames_left", 32'(exp_frames.size()), 32'd0);
    run = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("fault_sticky", 32'(fault), 32'd1);

    // run rising edge restarts; run then drops inside RD_WAIT.
    rd_values.push_back(24'hC0FFEE);
    applyStimulus(0, 0);
    repeat (2) @(negedge clk_in);
    checkOutput("restart_fault", 32'(fault), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd0);
    for (int i = 0; i < PWRUP_CYC + 200 && !(bus.i2c_en && bus.i2c_wr); i++) @(negedge clk_in);
    checkOutput("rd_timeout", 32'(bus.i2c_en && bus.i2c_wr), 32'd1);
    @(negedge clk_in);
    run = 1'b0;
    @(negedge clk_in);
    checkOutput("rd_en_held", 32'(bus.i2c_en), 32'd1);
    waitSamples(4, 50, "late_sample_timeout");
    repeat (40) @(negedge clk_in);
    checkOutput("late_busy", 32'(busy), 32'd0);
    checkOutput("late_en", 32'(bus.i2c_en), 32'd0);
    checkOutput("late_frames_left", 32'(exp_frames.size()), 32'd0);

    // Asynchronous reset in the middle of CFG_WAIT.
    exp_frames.push_back(CFG0);
    run = 1'b1;
    for (int i = 0; i < PWRUP_CYC + 100 && !bus.i2c_en; i++) @(negedge clk_in);
    checkOutput("cfg_timeout", 32'(bus.i2c_en), 32'd1);
    @(negedge clk_in);
    checkOutput("cfg_wait_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_en", 32'(bus.i2c_en), 32'd0);
    checkOutput("arst_wdata", bus.i2c_wdata, 32'd0);
    checkOutput("arst_rdata", bus.i2c_rdata, 32'd0);
    checkOutput("arst_nm", 32'(bus.i2c_nm), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_sample_data", 32'(sample_data), 32'd0);
    run = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("end_frames_left", 32'(exp_frames.size()), 32'd0);
    checkOutput("end_samples_left", 32'(exp_samples.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
